// File: rtl/code_defs_pkg.sv
// Shared types and constants for the receive-side AXIS frame fixup.
// Also provides the byte-lane popcount helper used by the length counter.
package code_defs_pkg;

  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned DATA_NBYTES   = DATA_WIDTH / 8;
  localparam int unsigned BCNT_WIDTH    = 16;
  localparam int unsigned ETH_MIN_FRAME = 64;
  localparam int unsigned ETH_MAX_FRAME = 1518;

  typedef enum logic [1:0] {
    SYNC,
    EMPTY,
    HOLD,
    FLUSH
  } state_t;

  typedef enum logic [1:0] {
    GOOD,
    CRC_ERR,
    OVERSIZE,
    RUNT
  } frame_class_t;

  function automatic logic [2:0] keep_bytes(input logic [DATA_NBYTES-1:0] keep);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < DATA_NBYTES; i++) begin
      n = n + {2'b00, keep[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_clear,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/rx_axis_frame_fixup.sv
// Re-times the MAC receive stream so TLAST sits on the last nonzero-keep beat,
// flags bad frames on TUSER and keeps per-class frame counters.
module rx_axis_frame_fixup
  import code_defs_pkg::*;
#(
  parameter int unsigned MIN_FRAME_BYTES = ETH_MIN_FRAME,
  parameter int unsigned MAX_FRAME_BYTES = ETH_MAX_FRAME,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [DATA_WIDTH-1:0]  s00_axis_tdata,
  input  logic [DATA_NBYTES-1:0] s00_axis_tkeep,
  input  logic                   s00_axis_tvalid,
  input  logic                   s00_axis_tlast,
  input  logic                   s00_axis_tuser,
  output logic [DATA_WIDTH-1:0]  m00_axis_tdata,
  output logic [DATA_NBYTES-1:0] m00_axis_tkeep,
  output logic                   m00_axis_tvalid,
  output logic                   m00_axis_tlast,
  output logic                   m00_axis_tuser,
  input  logic                   i_cnt_clear,
  output logic [CNT_WIDTH-1:0]   o_good_cnt,
  output logic [CNT_WIDTH-1:0]   o_crc_err_cnt,
  output logic [CNT_WIDTH-1:0]   o_oversize_cnt,
  output logic [CNT_WIDTH-1:0]   o_runt_cnt
);

  localparam logic [BCNT_WIDTH-1:0] MinBytes = BCNT_WIDTH'(MIN_FRAME_BYTES);
  localparam logic [BCNT_WIDTH-1:0] MaxBytes = BCNT_WIDTH'(MAX_FRAME_BYTES);

  state_t                 r_state;
  logic [BCNT_WIDTH-1:0]  r_bytes;
  logic [DATA_WIDTH-1:0]  r_hold_data;
  logic [DATA_NBYTES-1:0] r_hold_keep;
  logic                   r_hold_last;
  logic                   r_hold_bad;
  logic [DATA_WIDTH-1:0]  r_m_tdata;
  logic [DATA_NBYTES-1:0] r_m_tkeep;
  logic                   r_m_tvalid;
  logic                   r_m_tlast;
  logic                   r_m_tuser;

  logic                   w_data;
  logic                   w_end_empty;
  logic                   w_frame_end;
  logic [BCNT_WIDTH:0]    w_sum_ext;
  logic [BCNT_WIDTH-1:0]  w_sum;
  frame_class_t           w_class;
  logic                   w_bad;

  assign w_data      = s00_axis_tvalid && (s00_axis_tkeep != '0);
  assign w_end_empty = s00_axis_tvalid && s00_axis_tlast && (s00_axis_tkeep == '0);
  assign w_frame_end = s00_axis_tvalid && s00_axis_tlast && (r_state != SYNC);

  // Running length including the current beat, so the tlast beat is classified in-cycle.
  assign w_sum_ext = {1'b0, r_bytes} + {{(BCNT_WIDTH - 2){1'b0}}, keep_bytes(s00_axis_tkeep)};
  assign w_sum     = w_sum_ext[BCNT_WIDTH] ? {BCNT_WIDTH{1'b1}} : w_sum_ext[BCNT_WIDTH-1:0];

  always_comb begin
    w_class = GOOD;
    if (!s00_axis_tuser) begin
      w_class = CRC_ERR;
    end else if (w_sum > MaxBytes) begin
      w_class = OVERSIZE;
    end else if (w_sum < MinBytes) begin
      w_class = RUNT;
    end
  end

  assign w_bad = (w_class != GOOD);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= SYNC;
      r_bytes     <= '0;
      r_hold_data <= '0;
      r_hold_keep <= '0;
      r_hold_last <= 1'b0;
      r_hold_bad  <= 1'b0;
      r_m_tdata   <= '0;
      r_m_tkeep   <= '0;
      r_m_tvalid  <= 1'b0;
      r_m_tlast   <= 1'b0;
      r_m_tuser   <= 1'b0;
    end else begin
      r_m_tvalid <= 1'b0;
      r_m_tlast  <= 1'b0;
      r_m_tuser  <= 1'b0;

      if (s00_axis_tvalid && (r_state != SYNC)) begin
        r_bytes <= s00_axis_tlast ? '0 : w_sum;
      end

      unique case (r_state)
        SYNC: begin
          if (s00_axis_tvalid && s00_axis_tlast) begin
            r_state <= EMPTY;
          end
        end

        EMPTY, FLUSH: begin
          if (r_state == FLUSH) begin
            r_m_tdata  <= r_hold_data;
            r_m_tkeep  <= r_hold_keep;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= r_hold_last;
            r_m_tuser  <= r_hold_bad;
          end
          r_hold_last <= 1'b0;
          r_state     <= EMPTY;
          if (w_data) begin
            r_hold_data <= s00_axis_tdata;
            r_hold_keep <= s00_axis_tkeep;
            if (s00_axis_tlast) begin
              r_hold_last <= 1'b1;
              r_hold_bad  <= w_bad;
              r_state     <= FLUSH;
            end else begin
              r_state <= HOLD;
            end
          end
        end

        HOLD: begin
          if (w_data) begin
            r_m_tdata   <= r_hold_data;
            r_m_tkeep   <= r_hold_keep;
            r_m_tvalid  <= 1'b1;
            r_hold_data <= s00_axis_tdata;
            r_hold_keep <= s00_axis_tkeep;
            if (s00_axis_tlast) begin
              r_hold_last <= 1'b1;
              r_hold_bad  <= w_bad;
              r_state     <= FLUSH;
            end
          end else if (w_end_empty) begin
            // Zero-keep tlast: the held beat becomes the frame's last beat.
            r_m_tdata  <= r_hold_data;
            r_m_tkeep  <= r_hold_keep;
            r_m_tvalid <= 1'b1;
            r_m_tlast  <= 1'b1;
            r_m_tuser  <= w_bad;
            r_state    <= EMPTY;
          end
        end

        default: r_state <= SYNC;
      endcase
    end
  end

  assign m00_axis_tdata  = r_m_tdata;
  assign m00_axis_tkeep  = r_m_tkeep;
  assign m00_axis_tvalid = r_m_tvalid;
  assign m00_axis_tlast  = r_m_tlast;
  assign m00_axis_tuser  = r_m_tuser;

  logic w_inc_good;
  logic w_inc_crc;
  logic w_inc_over;
  logic w_inc_runt;

  assign w_inc_good = w_frame_end && (w_class == GOOD);
  assign w_inc_crc  = w_frame_end && (w_class == CRC_ERR);
  assign w_inc_over = w_frame_end && (w_class == OVERSIZE);
  assign w_inc_runt = w_frame_end && (w_class == RUNT);

  sat_counter #(.WIDTH(CNT_WIDTH)) u_good_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_cnt_clear),
    .i_inc   (w_inc_good),
    .o_count (o_good_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_crc_err_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_cnt_clear),
    .i_inc   (w_inc_crc),
    .o_count (o_crc_err_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_oversize_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_cnt_clear),
    .i_inc   (w_inc_over),
    .o_count (o_oversize_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_runt_cnt (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (i_cnt_clear),
    .i_inc   (w_inc_runt),
    .o_count (o_runt_cnt)
  );

endmodule

// File: tb/tb_rx_axis_frame_fixup.sv
// Scoreboard bench: expected output beats are queued as frames are driven and
// popped as the DUT emits them; counters are checked against a small model.
module tb_rx_axis_frame_fixup;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic [31:0]   s_tdata;
  logic [3:0]    s_tkeep;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tuser;
  logic [31:0]   m_tdata;
  logic [3:0]    m_tkeep;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tuser;
  logic          i_cnt_clear;
  logic [CW-1:0] good_cnt;
  logic [CW-1:0] crc_cnt;
  logic [CW-1:0] over_cnt;
  logic [CW-1:0] runt_cnt;

  always #5 i_clk = ~i_clk;

  rx_axis_frame_fixup #(
    .MIN_FRAME_BYTES (64),
    .MAX_FRAME_BYTES (1518),
    .CNT_WIDTH       (CW)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .s00_axis_tdata  (s_tdata),
    .s00_axis_tkeep  (s_tkeep),
    .s00_axis_tvalid (s_tvalid),
    .s00_axis_tlast  (s_tlast),
    .s00_axis_tuser  (s_tuser),
    .m00_axis_tdata  (m_tdata),
    .m00_axis_tkeep  (m_tkeep),
    .m00_axis_tvalid (m_tvalid),
    .m00_axis_tlast  (m_tlast),
    .m00_axis_tuser  (m_tuser),
    .i_cnt_clear     (i_cnt_clear),
    .o_good_cnt      (good_cnt),
    .o_crc_err_cnt   (crc_cnt),
    .o_oversize_cnt  (over_cnt),
    .o_runt_cnt      (runt_cnt)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;
  int    exp_good = 0;
  int    exp_crc  = 0;
  int    exp_over = 0;
  int    exp_runt = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  beat_t mon_e;
  always @(negedge i_clk) begin
    if (m_tvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {m_tdata, m_tkeep, m_tlast, m_tuser}, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("beat", {m_tdata, m_tkeep, m_tlast, m_tuser}, mon_e);
      end
    end
  end

  task automatic idle(input int n);
    s_tvalid    = 1'b0;
    s_tlast     = 1'b0;
    s_tkeep     = 4'h0;
    s_tuser     = 1'b0;
    i_cnt_clear = 1'b0;
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0;
    i_reset  = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset  = 1'b0;
    exp_good = 0;
    exp_crc  = 0;
    exp_over = 0;
    exp_runt = 0;
  endtask

  // abort_after>0: reset is applied after that many beats and the rest is
  // sent into the resynchronising DUT, so only the already-emitted beats appear.
  task automatic send_frame(input int nbytes, input bit crc_ok, input bit zero_tail,
                            input int gap, input int abort_after, input bit clear_on_last);
    logic [3:0]  keeps[$];
    logic [31:0] datas[$];
    logic [3:0]  k;
    int          rem;
    int          nd;
    int          cls;
    beat_t       b;
    rem = nbytes;
    while (rem >= 4) begin
      keeps.push_back(4'hF);
      rem -= 4;
    end
    if (rem > 0) begin
      k = 4'((1 << rem) - 1);
      keeps.push_back(k);
    end
    nd = keeps.size();
    if (zero_tail || nbytes == 0) keeps.push_back(4'h0);
    foreach (keeps[i]) datas.push_back($urandom);

    if (!crc_ok)            cls = 1;
    else if (nbytes > 1518) cls = 2;
    else if (nbytes < 64)   cls = 3;
    else                    cls = 0;

    for (int i = 0; i < nd; i++) begin
      if (abort_after == 0 || i < abort_after - 1) begin
        b.data = datas[i];
        b.keep = keeps[i];
        b.last = (abort_after == 0) && (i == nd - 1);
        b.user = b.last && (cls != 0);
        exp_q.push_back(b);
      end
    end

    for (int i = 0; i < keeps.size(); i++) begin
      if (abort_after > 0 && i == abort_after) do_reset();
      s_tvalid    = 1'b1;
      s_tdata     = datas[i];
      s_tkeep     = keeps[i];
      s_tlast     = (i == keeps.size() - 1);
      s_tuser     = s_tlast ? crc_ok : 1'b0;
      i_cnt_clear = clear_on_last && s_tlast;
      @(posedge i_clk);
      #1;
    end
    s_tvalid    = 1'b0;
    s_tlast     = 1'b0;
    i_cnt_clear = 1'b0;

    if (abort_after == 0) begin
      if (clear_on_last) begin
        exp_good = 0;
        exp_crc  = 0;
        exp_over = 0;
        exp_runt = 0;
      end else begin
        case (cls)
          0:       exp_good = sat_inc(exp_good);
          1:       exp_crc  = sat_inc(exp_crc);
          2:       exp_over = sat_inc(exp_over);
          default: exp_runt = sat_inc(exp_runt);
        endcase
      end
    end
    if (gap > 0) idle(gap);
  endtask

  task automatic check_cnts(input string tag);
    idle(3);
    check({tag, "_good"}, good_cnt, exp_good);
    check({tag, "_crc"},  crc_cnt,  exp_crc);
    check({tag, "_over"}, over_cnt, exp_over);
    check({tag, "_runt"}, runt_cnt, exp_runt);
  endtask

  initial begin
    int waited;
    i_reset     = 1'b1;
    s_tdata     = '0;
    s_tkeep     = 4'h0;
    s_tvalid    = 1'b0;
    s_tlast     = 1'b0;
    s_tuser     = 1'b0;
    i_cnt_clear = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    i_reset = 1'b0;

    check("rst_tvalid", m_tvalid, 0);
    check("rst_tlast",  m_tlast,  0);
    check("rst_tuser",  m_tuser,  0);
    check_cnts("rst");

    // Partial frame right after reset must be discarded silently.
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = $urandom;
      s_tkeep  = 4'hF;
      s_tlast  = (i == 3);
      s_tuser  = 1'b1;
      @(posedge i_clk);
      #1;
    end
    idle(2);
    check_cnts("sync");

    send_frame(64, 1'b1, 1'b0, 3, 0, 1'b0);
    check_cnts("f64");
    send_frame(66, 1'b1, 1'b1, 3, 0, 1'b0);
    check_cnts("f66");
    send_frame(66, 1'b0, 1'b1, 3, 0, 1'b0);
    check_cnts("f66crc");
    send_frame(40, 1'b1, 1'b0, 3, 0, 1'b0);
    check_cnts("runt40");
    send_frame(1600, 1'b1, 1'b0, 3, 0, 1'b0);
    check_cnts("over1600");
    send_frame(0, 1'b1, 1'b0, 3, 0, 1'b0);
    check_cnts("zero_len");
    send_frame(63, 1'b1, 1'b0, 3, 0, 1'b0);
    send_frame(1518, 1'b1, 1'b1, 3, 0, 1'b0);
    send_frame(1519, 1'b1, 1'b0, 3, 0, 1'b0);
    check_cnts("bounds");

    // Back-to-back frames: the next frame starts while the previous one flushes.
    send_frame(65, 1'b1, 1'b0, 0, 0, 1'b0);
    send_frame(64, 1'b0, 1'b0, 0, 0, 1'b0);
    send_frame(70, 1'b1, 1'b1, 0, 0, 1'b0);
    send_frame(8, 1'b1, 1'b0, 2, 0, 1'b0);
    check_cnts("b2b");

    send_frame(64, 1'b1, 1'b0, 2, 5, 1'b0);
    check_cnts("abort");
    send_frame(64, 1'b1, 1'b0, 3, 0, 1'b0);
    check_cnts("after_abort");

    for (int i = 0; i < 16; i++) send_frame(64, 1'b1, 1'b0, 1, 0, 1'b0);
    check_cnts("saturate");

    send_frame(64, 1'b1, 1'b0, 3, 0, 1'b1);
    check_cnts("clear");

    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge i_clk);
      waited++;
    end
    #1;
    check("drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
